// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } fetch_state_t;

  localparam int          FETCH_DEPTH = 2;
  localparam int          PC_STEP     = 4;
  localparam logic [31:0] ZERO_INST   = 32'h0;
  localparam int          IMEM_WORDS  = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO with synchronous flush; push and pop may coincide even when full.
module fetch_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC, fetch FSM, ROM word selection and prefetch FIFO.
// Optional halt-on-zero-word behaviour is enabled with FETCH_HALT_ON_ZERO_EN.
//
// state   | meaning
// S_FETCH | fetching sequentially from pc when not stalled and FIFO has room
// S_HALT  | zero word seen; pc frozen until redirect or reset
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int N     = 32,
  parameter int PCW   = 64,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  output logic [5:0]     imem_addr,
  input  logic [N-1:0]   imem_q,
  input  logic           stall,
  input  logic           redirect,
  input  logic [PCW-1:0] redirect_pc,
  output logic           inst_valid,
  input  logic           inst_ready,
  output logic [N-1:0]   inst_data,
  output logic [PCW-1:0] inst_pc,
  output logic           halted
);

  fetch_state_t   state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [N-1:0]   word;
  logic           fifo_full, fifo_empty;
  logic [PCW+N-1:0] fifo_rdata;
  logic           deq, fetch_en, push, zero_hit;
  logic           unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_addr = pc_q[7:2];
  // Anything outside the 256-byte ROM window reads as a zero word.
  assign word      = (pc_q[PCW-1:8] == '0 && pc_q[1:0] == 2'b00) ? imem_q : '0;
  assign deq       = inst_valid && inst_ready && !redirect;
  assign fetch_en  = (state_q == S_FETCH) && !stall && !redirect && (!fifo_full || deq);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_hit = fetch_en && (word == N'(ZERO_INST));
  assign halted   = (state_q == S_HALT);
`else
  assign zero_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign push = fetch_en && !zero_hit;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      state_d = S_FETCH;
      pc_d    = {redirect_pc[PCW-1:2], 2'b00};
    end else if (zero_hit) begin
      state_d = S_HALT;
    end else if (push) begin
      pc_d = pc_q + PCW'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .W     (PCW + N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (deq),
    .wdata ({pc_q, word}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_empty ? '0 : fifo_rdata[N-1:0];
  assign inst_pc    = fifo_empty ? '0 : fifo_rdata[PCW+N-1:N];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-level reference model plus directed literal checks.
module tb_fetch_ctrl;

  localparam int DEPTH = 2;
`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        halted;

  logic [31:0] rom [64];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en = 1'b0;

  logic [95:0] mq [$];
  logic [63:0] mpc = '0;
  bit          mhalt = 1'b0;
  bit          m_deq, m_go;
  logic [31:0] m_word;

  always #5 clk = ~clk;

  assign imem_q = rom[imem_addr];

  fetch_ctrl #(.N(32), .PCW(64), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .halted      (halted)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of {pc, data} entries updated at each rising edge.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      mq.delete();
      mpc   = '0;
      mhalt = 1'b0;
    end else if (redirect) begin
      mq.delete();
      mpc   = redirect_pc & ~64'h3;
      mhalt = 1'b0;
    end else begin
      m_deq  = (mq.size() != 0) && inst_ready;
      m_go   = !mhalt && !stall && ((mq.size() < DEPTH) || m_deq);
      m_word = (mpc < 64'h100) ? rom[mpc[7:2]] : 32'h0;
      if (m_deq) void'(mq.pop_front());
      if (m_go) begin
        if (HALT_EN && m_word == 32'h0) mhalt = 1'b1;
        else begin
          mq.push_back({mpc, m_word});
          mpc = mpc + 64'd4;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_valid",  {63'd0, inst_valid}, {63'd0, mq.size() != 0});
      chk("m_pc",     inst_pc, (mq.size() != 0) ? mq[0][95:32] : 64'd0);
      chk("m_data",   {32'd0, inst_data}, (mq.size() != 0) ? {32'd0, mq[0][31:0]} : 64'd0);
      chk("m_addr",   {58'd0, imem_addr}, {58'd0, mpc[7:2]});
      chk("m_halted", {63'd0, halted}, {63'd0, mhalt});
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | i;
    rom[0] = 32'h8b0f0101;
    rom[1] = 32'h11;
    rom[2] = 32'h22;
    rom[3] = 32'h33;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_valid",  {63'd0, inst_valid}, 64'd0);
    chk("rst_data",   {32'd0, inst_data}, 64'd0);
    chk("rst_pc",     inst_pc, 64'd0);
    chk("rst_addr",   {58'd0, imem_addr}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);

    // Streaming at one instruction per cycle.
    reset = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    chk("s0_valid", {63'd0, inst_valid}, 64'd1);
    chk("s0_pc",    inst_pc, 64'h0);
    chk("s0_data",  {32'd0, inst_data}, 64'h8b0f0101);
    @(negedge clk);
    chk("s1_pc",    inst_pc, 64'h4);
    chk("s1_data",  {32'd0, inst_data}, 64'h11);
    @(negedge clk);
    chk("s2_pc",    inst_pc, 64'h8);
    chk("s2_data",  {32'd0, inst_data}, 64'h22);
    @(negedge clk);
    chk("s3_pc",    inst_pc, 64'hC);
    chk("s3_data",  {32'd0, inst_data}, 64'h33);

    // One-cycle reset in the middle of the stream.
    reset = 1'b1;
    @(negedge clk);
    chk("mr_valid", {63'd0, inst_valid}, 64'd0);
    chk("mr_pc",    inst_pc, 64'd0);
    chk("mr_data",  {32'd0, inst_data}, 64'd0);
    chk("mr_addr",  {58'd0, imem_addr}, 64'd0);

    // Back-pressure fills the FIFO, then drains in order.
    reset = 1'b0; inst_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp_addr",  {58'd0, imem_addr}, 64'd2);
    chk("bp_valid", {63'd0, inst_valid}, 64'd1);
    chk("bp_pc",    inst_pc, 64'h0);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("dr0_pc", inst_pc, 64'h4);
    @(negedge clk);
    chk("dr1_pc", inst_pc, 64'h8);

    // Misaligned redirect while the FIFO is full.
    inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    redirect = 1'b1; redirect_pc = 64'h2E; inst_ready = 1'b1;
    @(negedge clk);
    chk("rd_valid", {63'd0, inst_valid}, 64'd0);
    chk("rd_addr",  {58'd0, imem_addr}, 64'd11);
    redirect = 1'b0;
    @(negedge clk);
    chk("rd_tvalid", {63'd0, inst_valid}, 64'd1);
    chk("rd_tpc",    inst_pc, 64'h2C);
    chk("rd_tdata",  {32'd0, inst_data}, 64'h1000_000B);

    // Stall with a queued entry and decode ready.
    stall = 1'b1;
    repeat (3) @(negedge clk);
    chk("st_valid", {63'd0, inst_valid}, 64'd0);
    chk("st_addr",  {58'd0, imem_addr}, 64'd12);
    stall = 1'b0;
    @(negedge clk);
    chk("st_resume_pc", inst_pc, 64'h30);

    // Redirect outside the ROM window: zero words.
    redirect = 1'b1; redirect_pc = 64'h100;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    if (HALT_EN) begin
      chk("z_halted", {63'd0, halted}, 64'd1);
      chk("z_valid",  {63'd0, inst_valid}, 64'd0);
      repeat (3) @(negedge clk);
      chk("z_hold_halted", {63'd0, halted}, 64'd1);
      chk("z_hold_addr",   {58'd0, imem_addr}, 64'd0);
    end else begin
      chk("z_valid", {63'd0, inst_valid}, 64'd1);
      chk("z_pc0",   inst_pc, 64'h100);
      chk("z_data0", {32'd0, inst_data}, 64'd0);
      @(negedge clk);
      chk("z_pc1",   inst_pc, 64'h104);
      chk("z_data1", {32'd0, inst_data}, 64'd0);
    end

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFD;
    @(negedge clk);
    chk("w_halted", {63'd0, halted}, 64'd0);
    chk("w_addr",   {58'd0, imem_addr}, 64'h3F);
    redirect = 1'b0;
    @(negedge clk);
    if (HALT_EN) begin
      chk("w_halt", {63'd0, halted}, 64'd1);
    end else begin
      chk("w_pc_top", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      @(negedge clk);
      chk("w_pc_wrap",   inst_pc, 64'h0);
      chk("w_data_wrap", {32'd0, inst_data}, 64'h8b0f0101);
    end

    // Redirect back to 0 clears any halt.
    redirect = 1'b1; redirect_pc = 64'h0;
    @(negedge clk);
    chk("x_halted", {63'd0, halted}, 64'd0);
    redirect = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the 64-word instruction ROM (`imem`) for the LEGv8 core. Owns the program counter and drives the ROM word address each cycle. Captures the combinational ROM output into a 2-entry prefetch FIFO and presents instructions to decode over a valid/ready handshake. Handles branch redirects, front-end stalls and, optionally, halting on an all-zero word.

## Interface
- `N`, 32, instruction width; must match `imem`.
- `PCW`, 64, program-counter width in bits (byte address).
- `DEPTH`, 2, prefetch FIFO entries; power of two, at least 2.

Ports, clock and reset first:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_addr`  out  6  word address to `imem` (`pc[7:2]`).
- `imem_q`  in  N  combinational ROM data for `imem_addr`.
- `stall`  in  1  freezes fetching; PC held, no enqueue.
- `redirect`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  PCW  new byte PC; bits [1:0] ignored and forced to 0.
- `inst_valid`  out  1  FIFO head holds a valid instruction.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `inst_data`  out  N  head instruction.
- `inst_pc`  out  PCW  byte PC of the head instruction.
- `halted`  out  1  fetch stopped by the zero-word rule.

## Operation
- FSM states are `S_FETCH` and `S_HALT`. Reset enters `S_FETCH`.
- Fetch condition: the cycle is in `S_FETCH`, `stall`=0, `redirect`=0, and either the FIFO is not full or a dequeue happens in the same cycle.
  - On fetch: enqueue `{pc, word}`, then `pc <= pc + 4`.
- Word selection:
  - `word = imem_q` when `pc[PCW-1:8]` is 0 and `pc[1:0]` is 0.
  - Otherwise `word = 0`.
- Dequeue occurs when `inst_valid && inst_ready`.
- Redirect has priority over everything else:
  - FIFO is flushed (count 0).
  - `pc <= {redirect_pc[PCW-1:2], 2'b00}`.
  - State becomes `S_FETCH` and `halted` is cleared.
  - No enqueue or dequeue takes effect that cycle; a same-cycle `inst_ready` is discarded.
- A stall on its own has no effect on dequeue.
- A stall together with a redirect: the redirect still applies.
- PC arithmetic wraps modulo 2^PCW.
- Outputs: `inst_data`/`inst_pc` are 0 whenever the FIFO is empty.
- Reset mid-operation: FIFO is flushed and all state returns to reset values the following cycle.

## Timing
- Reset values:
  - `pc` = 0, `imem_addr` = 0
  - `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0
  - `halted` = 0, FIFO count = 0
- `imem_addr` is combinational from the `pc` register, so the ROM read is zero-wait.
- Latency:
  - First cycle after reset deasserts: word 0 is enqueued.
  - `inst_valid`=1 in the following cycle.
  - After a redirect, the first target instruction is valid 2 cycles after the redirect cycle.
- Throughput: 1 instruction/cycle when `inst_ready` is held at 1.
- Full FIFO with `inst_ready`=0: PC holds and `imem_addr` is stable.

## Configuration
- Macro: `FETCH_HALT_ON_ZERO_EN`.
- Defined:
  - A fetch whose `word` is 32'h0 is not enqueued.
  - `pc` holds at the zero word's address.
  - FSM moves to `S_HALT` and `halted`=1 from the next cycle.
  - Instructions already queued still drain.
  - Exit `S_HALT` only via `redirect` or `reset`.
- Undefined:
  - A zero word is enqueued like any other instruction.
  - `S_HALT` is unreachable; `halted` is tied to 0.

## Structure
- `fetch_pkg` holds:
  - `fetch_state_t` enum (`S_FETCH`, `S_HALT`)
  - `FETCH_DEPTH` default
  - `PC_STEP` = 4
  - `ZERO_INST` = 32'h0
  - `IMEM_WORDS` = 64
- One sub-module, `fetch_fifo`:
  - Parameterised width/depth.
  - Synchronous flush; `full`/`empty` outputs.
  - Simultaneous push/pop allowed when full.
- `fetch_ctrl` holds the PC, FSM and word selection.

## Test plan
- ROM words 0..3 = 8b0f0101, 11, 22, 33; `inst_ready`=1 → from cycle 2 after reset, `inst_pc` = 0, 4, 8, C with matching data, one per cycle.
- `inst_ready`=0 for 5 cycles → FIFO fills (2 entries), `imem_addr` stays at 2, PC = 8; on release, entries drain in order with no loss or duplication.
- Redirect to 0x2E (misaligned) while FIFO is full, with `inst_ready`=1 → FIFO emptied; next `inst_valid` shows `inst_pc`=0x2C; the pre-redirect head is never accepted.
- Redirect to 0x100 → fetched words are 0. With `FETCH_HALT_ON_ZERO_EN` defined: `halted`=1 one cycle later, `inst_valid`=0, PC holds 0x100. Without the macro: zero instructions stream.
- `stall`=1 for 3 cycles with a queued entry and `inst_ready`=1 → the entry dequeues, PC is frozen, nothing new is enqueued.
- `reset` asserted mid-stream for 1 cycle → next cycle all outputs are at reset values; fetch restarts at PC 0.
